// File: rtl/wb_pkg.sv
// Shared constants and the long-latency result entry type for the
// register-file writeback arbiter.
package wb_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 2 ** REG_AW;

   // One queued long-latency result: destination register and its value.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency writeback entries.
// Head is the oldest entry and is valid whenever empty is low.
// Push on full and pop on empty are ignored so the pointers can never slip.
module wb_fifo
   import wb_pkg::*;
#(
   parameter type entry_t = wb_entry_t,
   parameter int  DEPTH   = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t wr_entry,
   input  logic   pop,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   localparam int PW = $clog2(DEPTH);

   entry_t          mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [PW:0]     count_r;
   logic            push_ok_s;
   logic            pop_ok_s;

   assign full      = (count_r == (PW+1)'(DEPTH));
   assign empty     = (count_r == (PW+1)'(0));
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign head      = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= (PW+1)'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_entry;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writer-side front end for the register file write port.
// Pipeline writebacks always win the port; queued long-latency results
// drain into cycles the pipeline leaves idle. A per-register pending
// scoreboard stalls decode on hazards against outstanding long-latency
// writes, which also keeps pipeline writes from overtaking queued ones.
module reg_wb_arbiter #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_we,
   input  logic [REG_AW-1:0]    wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 ll_valid,
   output logic                 ll_ready,
   input  logic [REG_AW-1:0]    ll_rd,
   input  logic [XLEN-1:0]      ll_data,
   input  logic                 iss_valid,
   input  logic [REG_AW-1:0]    iss_rd,
   input  logic [REG_AW-1:0]    id_rs1,
   input  logic [REG_AW-1:0]    id_rs2,
   input  logic [REG_AW-1:0]    id_rd,
   input  logic                 id_rd_we,
   output logic                 stall,
   output logic                 WE3,
   output logic [REG_AW-1:0]    AD3,
   output logic [XLEN-1:0]      WD3,
   output logic [2**REG_AW-1:0] pending,
   output logic                 err
);

   import wb_pkg::*;

   localparam int NR = 2 ** REG_AW;

   wb_entry_t          push_entry_s;
   wb_entry_t          head_s;
   logic               full_s;
   logic               empty_s;
   logic               ll_ready_s;
   logic               push_s;
   logic               pipe_act_s;
   logic               drain_s;
   logic [NR-1:0]      pending_r;
   logic [NR-1:0]      set_mask_s;
   logic [NR-1:0]      clr_mask_s;
   logic [NR-1:0]      pending_next_s;
   logic               err_r;
   logic               err_set_s;

   // Input acceptance is not pop-aware and is held off during reset.
   assign ll_ready_s = !rst && !full_s;
   assign ll_ready   = ll_ready_s;

   // Results for x0 are acknowledged but never stored.
   assign push_s          = ll_valid && ll_ready_s && (ll_rd != REG_AW'(0));
   assign push_entry_s.rd   = ll_rd;
   assign push_entry_s.data = ll_data;

   assign pipe_act_s = wb_we && (wb_rd != REG_AW'(0));
   assign drain_s    = !rst && !pipe_act_s && !empty_s;

   wb_fifo #(
      .entry_t (wb_entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_s),
      .wr_entry (push_entry_s),
      .pop      (drain_s),
      .head     (head_s),
      .full     (full_s),
      .empty    (empty_s)
   );

   // Write-port mux: pipeline first, then FIFO head, otherwise idle at zero.
   always_comb begin
      WE3 = 1'b0;
      AD3 = REG_AW'(0);
      WD3 = XLEN'(0);
      if (rst) begin
         WE3 = 1'b0;
      end else if (pipe_act_s) begin
         WE3 = 1'b1;
         AD3 = wb_rd;
         WD3 = wb_data;
      end else if (!empty_s) begin
         WE3 = 1'b1;
         AD3 = head_s.rd;
         WD3 = head_s.data;
      end else begin
         WE3 = 1'b0;
      end
   end

   // Scoreboard update masks: issue sets, drain clears, set wins, x0 never pending.
   always_comb begin
      set_mask_s     = {NR{1'b0}};
      clr_mask_s     = {NR{1'b0}};
      if (iss_valid) begin
         set_mask_s = {{(NR-1){1'b0}}, 1'b1} << iss_rd;
      end else begin
         set_mask_s = {NR{1'b0}};
      end
      if (drain_s) begin
         clr_mask_s = {{(NR-1){1'b0}}, 1'b1} << head_s.rd;
      end else begin
         clr_mask_s = {NR{1'b0}};
      end
      pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s)
                       & ~{{(NR-1){1'b0}}, 1'b1};
   end

   // Pending scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= {NR{1'b0}};
      end else begin
         pending_r <= pending_next_s;
      end
   end

   assign pending = pending_r;

   // Decode hazard detection against outstanding long-latency writes.
   always_comb begin
      stall = 1'b0;
      if (rst) begin
         stall = 1'b0;
      end else begin
         stall = ((id_rs1 != REG_AW'(0)) && pending_r[id_rs1]) ||
                 ((id_rs2 != REG_AW'(0)) && pending_r[id_rs2]) ||
                 (id_rd_we && (id_rd != REG_AW'(0)) && pending_r[id_rd]);
      end
   end

   // Protocol violations: unexpected long-latency result, or pipeline write
   // to a register still owed a long-latency result.
   assign err_set_s = (push_s && !pending_r[ll_rd]) ||
                      (pipe_act_s && pending_r[wb_rd]);

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (err_set_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err = err_r;

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Writer-side front end for the register file's single write port (WE3/AD3/WD3).
- Merges single-cycle pipeline writebacks with results from long-latency units (multiply/divide, load miss) delivered over a valid/ready handshake.
- Buffers long-latency results in a small FIFO and drains them into idle write-port cycles.
- Keeps a per-register pending scoreboard and raises a decode stall on RAW/WAW hazards against outstanding long-latency writes.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width (2**REG_AW registers).
- DEPTH, 4, long-latency result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- wb_we  in  1  pipeline writeback enable.
- wb_rd  in  REG_AW  pipeline writeback destination.
- wb_data  in  XLEN  pipeline writeback data.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  FIFO can accept a result.
- ll_rd  in  REG_AW  long-latency result destination.
- ll_data  in  XLEN  long-latency result data.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_rd  in  REG_AW  destination of the issued op.
- id_rs1  in  REG_AW  decode-stage source 1.
- id_rs2  in  REG_AW  decode-stage source 2.
- id_rd  in  REG_AW  decode-stage destination.
- id_rd_we  in  1  decode instruction writes id_rd.
- stall  out  1  decode must stall (combinational).
- WE3  out  1  register file write enable.
- AD3  out  REG_AW  register file write address.
- WD3  out  XLEN  register file write data.
- pending  out  2**REG_AW  scoreboard bits, registered.
- err  out  1  sticky protocol error, registered.

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, pointers 0, pending=0, err=0. While rst is high: WE3=0, AD3=0, WD3=0, ll_ready=0, stall=0. Reset mid-drain discards all FIFO contents.
- ll_ready = !full. It is not pop-aware: a full FIFO refuses input even in a cycle where it pops.
- Push at posedge on ll_valid && ll_ready. Results with ll_rd==0 are accepted and discarded (never pushed).
- Pipeline writes have absolute priority. pipe_act = wb_we && wb_rd!=0.
  - If pipe_act: WE3=1, AD3=wb_rd, WD3=wb_data, combinationally in the same cycle. No pop.
  - Else if FIFO non-empty: WE3=1, AD3=head.rd, WD3=head.data; pop at posedge.
  - Else: WE3=0, AD3=0, WD3=0.
- No bypass: minimum latency is 1 cycle from accept to WE3.
- Push and pop in the same cycle: both take effect; count unchanged.
- Pointers wrap modulo DEPTH.
- Scoreboard:
  - Set: iss_valid && iss_rd!=0 sets pending[iss_rd] at posedge.
  - Clear: a FIFO drain write clears pending[head.rd].
  - Set and clear of the same bit in one cycle: set wins. Bit 0 is always 0.
- stall=1 when any of these holds:
  - id_rs1!=0 && pending[id_rs1]
  - id_rs2!=0 && pending[id_rs2]
  - id_rd_we && id_rd!=0 && pending[id_rd]
- Consequence: no pipeline write ever targets a register with a queued result, so WAW ordering is guaranteed.
- err sets (sticky until rst) on:
  - an accepted ll result with ll_rd!=0 and pending[ll_rd]==0;
  - pipe_act with pending[wb_rd]==1.

Decomposition:
- Package wb_pkg: XLEN, REG_AW, NREGS; typedef wb_entry_t packed struct {rd, data}.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty and head output.
- Arbitration, scoreboard and stall logic stay in reg_wb_arbiter.

Test Plan:
- Reset, then idle cycles -> WE3=0, pending=0, ll_ready=1, err=0.
- Issue rd=5; 3 cycles later ll result rd=5, data=0xDEADBEEF with wb_we=0 -> accepted; next cycle WE3=1, AD3=5, WD3=0xDEADBEEF; pending[5] cleared the following posedge.
- Pipeline writes every cycle (wb_rd=7) while 4 ll results (rd 1-4, all pre-issued) arrive -> FIFO fills, ll_ready=0 on the 5th result, AD3 stays 7 throughout; after wb_we drops, rd 1,2,3,4 are drained in order on 4 consecutive cycles.
- pending[9]=1 with id_rs2=9 -> stall=1; id_rs1=0 with pending[0] forced by iss_rd=0 -> stall=0 and pending[0] stays 0.
- Same-cycle issue rd=6 and drain of rd=6 -> pending[6] remains 1.
- ll result for a non-pending rd=12 -> err=1 and stays 1 until rst; rst asserted with 2 queued entries -> FIFO empties and WE3=0 after release.
